// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over one shared 4x4 multiplier
module mult8_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_cin,
    input  logic [7:0]  mul_product
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [15:0] term;
    logic [15:0] sum;

    assign mul_cin = 1'b0;

    // Step order: aL*bL, aH*bL, aL*bH, aH*bH; the nibble ports rest at zero outside MUL.
    always_comb begin
        mul_a = 4'h0;
        mul_b = 4'h0;
        if (state == MUL) begin
            mul_a = step[0] ? a_q[7:4] : a_q[3:0];
            mul_b = step[1] ? b_q[7:4] : b_q[3:0];
        end
    end

    always_comb begin
        term = 16'h0000;
        case (step)
            2'd0:    term = {8'h00, mul_product};
            2'd1,
            2'd2:    term = {4'h0, mul_product, 4'h0};
            default: term = {mul_product, 8'h00};
        endcase
        sum = acc + term;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step    <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc     <= 16'h0000;
            product <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= 16'h0000;
                        step  <= 2'd0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        product <= sum;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - directed scoreboard bench for mult8_seq_ctrl
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_cin;
    logic [7:0]  mul_product;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the external 4x4 multiplier.
    assign mul_product = {4'h0, mul_a} * {4'h0, mul_b};

    mult8_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_cin    (mul_cin),
        .mul_product(mul_product)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_busy"}, {15'h0, busy}, 16'h0);
        chk({tag, "_done"}, {15'h0, done}, 16'h0);
        chk({tag, "_product"}, product, 16'h0000);
        chk({tag, "_mul_a"}, {12'h0, mul_a}, 16'h0);
        chk({tag, "_mul_b"}, {12'h0, mul_b}, 16'h0);
    endtask

    // Issue one operation and follow it to its done pulse; disturb re-pulses start
    // with new operands while the sequencer is in MUL.
    task automatic run_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                          input bit disturb);
        int cyc;
        int busy_cnt;
        logic [3:0] ema;
        logic [3:0] emb;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = oa;
        b     = ob;
        exp_q.push_back(16'(oa) * 16'(ob));
        seen     = 1'b0;
        busy_cnt = 0;
        cyc      = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && i == 2) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h11;
            end
            if (busy) busy_cnt++;
            if (i <= 4) begin
                ema = (i == 2 || i == 4) ? oa[7:4] : oa[3:0];
                emb = (i >= 3) ? ob[7:4] : ob[3:0];
                chk($sformatf("%s_mul_a_s%0d", tag, i - 1), {12'h0, mul_a}, {12'h0, ema});
                chk($sformatf("%s_mul_b_s%0d", tag, i - 1), {12'h0, mul_b}, {12'h0, emb});
            end
            if (done) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_latency"}, 16'(cyc), 16'd5);
        chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd5);
        if (exp_q.size() > 0) begin
            if (seen) chk({tag, "_product"}, product, exp_q[0]);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, {15'h0, done}, 16'h0);
        chk({tag, "_busy_after"}, {15'h0, busy}, 16'h0);
        chk({tag, "_product_hold"}, product, 16'(oa) * 16'(ob));
    endtask

    initial begin
        int cyc;
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_reset_values("reset");
        chk("mul_cin", {15'h0, mul_cin}, 16'h0);

        run_op("t12x34", 8'h12, 8'h34, 1'b0);
        run_op("tFFxFF", 8'hFF, 8'hFF, 1'b0);
        run_op("t00xA7", 8'h00, 8'hA7, 1'b0);
        run_op("tA5x3C", 8'hA5, 8'h3C, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("disturb_no_extra_done", {15'h0, done}, 16'h0);
        end

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h10;
        exp_q.push_back(16'h00F0);
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_first_seen", {15'h0, seen}, 16'h1);
        if (exp_q.size() > 0) begin
            chk("b2b_first_product", product, exp_q[0]);
            void'(exp_q.pop_front());
        end
        a = 8'h10;
        b = 8'h10;
        exp_q.push_back(16'h0100);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
            chk($sformatf("b2b_hold_c%0d", i), product, 16'h00F0);
        end
        start = 1'b0;
        chk("b2b_spacing", 16'(cyc), 16'd6);
        if (exp_q.size() > 0) begin
            chk("b2b_second_product", product, exp_q[0]);
            void'(exp_q.pop_front());
        end
        repeat (2) @(negedge clk);

        // Reset during step2 discards the operation.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h02;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_step2_mul_a", {12'h0, mul_a}, 16'h000F);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset_values("abort");
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {15'h0, seen}, 16'h0);
        run_op("t03x05", 8'h03, 8'h05, 1'b0);

        // Reset and start together: reset wins.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h22;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle_reset_values("rst_start");
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("rst_start_stays_idle", {15'h0, seen}, 16'h0);

        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
